// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - HI/LO register pair with speculative M/W write slots and EX forwarding
module hilo_unit #(
    parameter logic [31:0] RST_HI = 32'h0,
    parameter logic [31:0] RST_LO = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  hilo_opE,
    input  logic [63:0] alu_outE,
    input  logic        stallE,
    input  logic        stallM,
    input  logic        flushM,
    output logic [31:0] hiE,
    output logic [31:0] loE,
    output logic [31:0] hi_arch,
    output logic [31:0] lo_arch,
    output logic        busy
);

    // Operation encodings carried on hilo_opE; 6 and 7 behave as no-ops.
    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_MTHI  = 3'd2;
    localparam logic [2:0] OP_MTLO  = 3'd3;
    localparam logic [2:0] OP_MADD  = 3'd4;
    localparam logic [2:0] OP_MSUB  = 3'd5;

    // M slot: youngest speculative write, may still be killed by a MEM exception.
    logic        r_m_valid;
    logic        r_m_we_hi;
    logic        r_m_we_lo;
    logic [31:0] r_m_hi;
    logic [31:0] r_m_lo;

    // W slot: survived MEM, commits to the architectural pair when it leaves.
    logic        r_w_valid;
    logic        r_w_we_hi;
    logic        r_w_we_lo;
    logic [31:0] r_w_hi;
    logic [31:0] r_w_lo;

    // Architectural HI/LO.
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    // Forwarding qualifiers per half.
    logic        w_fwd_m_hi;
    logic        w_fwd_m_lo;
    logic        w_fwd_w_hi;
    logic        w_fwd_w_lo;

    // E-stage candidate write.
    logic        w_e_issue;
    logic        w_e_we_hi;
    logic        w_e_we_lo;
    logic [31:0] w_e_hi;
    logic [31:0] w_e_lo;
    logic [63:0] w_acc;
    logic [63:0] w_acc_add;
    logic [63:0] w_acc_sub;

    assign w_fwd_m_hi = r_m_valid & r_m_we_hi;
    assign w_fwd_m_lo = r_m_valid & r_m_we_lo;
    assign w_fwd_w_hi = r_w_valid & r_w_we_hi;
    assign w_fwd_w_lo = r_w_valid & r_w_we_lo;

    // Forward each half independently: youngest pending write wins, then W, then arch.
    always_comb begin
        hiE = r_hi;
        loE = r_lo;
        if (w_fwd_m_hi) begin
            hiE = r_m_hi;
        end else if (w_fwd_w_hi) begin
            hiE = r_w_hi;
        end
        if (w_fwd_m_lo) begin
            loE = r_m_lo;
        end else if (w_fwd_w_lo) begin
            loE = r_w_lo;
        end
    end

    // MADD/MSUB accumulate onto the forwarded value so chained ops see each other.
    assign w_acc     = {hiE, loE};
    assign w_acc_add = w_acc + alu_outE;
    assign w_acc_sub = w_acc - alu_outE;

    // Build the write that the op in E would place into the M slot.
    always_comb begin
        w_e_issue = 1'b0;
        w_e_we_hi = 1'b0;
        w_e_we_lo = 1'b0;
        w_e_hi    = 32'h0;
        w_e_lo    = 32'h0;
        case (hilo_opE)
            OP_WRITE: begin
                w_e_issue = 1'b1;
                w_e_we_hi = 1'b1;
                w_e_we_lo = 1'b1;
                w_e_hi    = alu_outE[63:32];
                w_e_lo    = alu_outE[31:0];
            end
            OP_MTHI: begin
                w_e_issue = 1'b1;
                w_e_we_hi = 1'b1;
                w_e_hi    = alu_outE[31:0];
            end
            OP_MTLO: begin
                w_e_issue = 1'b1;
                w_e_we_lo = 1'b1;
                w_e_lo    = alu_outE[31:0];
            end
            OP_MADD: begin
                w_e_issue = 1'b1;
                w_e_we_hi = 1'b1;
                w_e_we_lo = 1'b1;
                w_e_hi    = w_acc_add[63:32];
                w_e_lo    = w_acc_add[31:0];
            end
            OP_MSUB: begin
                w_e_issue = 1'b1;
                w_e_we_hi = 1'b1;
                w_e_we_lo = 1'b1;
                w_e_hi    = w_acc_sub[63:32];
                w_e_lo    = w_acc_sub[31:0];
            end
            OP_NONE: begin
                w_e_issue = 1'b0;
            end
            default: begin
                w_e_issue = 1'b0;
            end
        endcase
    end

    // M slot: capture the E write unless EX is stalled (bubble); a flush under stallM only kills it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_we_hi <= 1'b0;
            r_m_we_lo <= 1'b0;
            r_m_hi    <= 32'h0;
            r_m_lo    <= 32'h0;
        end else if (stallM) begin
            if (flushM) begin
                r_m_valid <= 1'b0;
            end
        end else begin
            r_m_valid <= w_e_issue & ~stallE;
            r_m_we_hi <= w_e_we_hi;
            r_m_we_lo <= w_e_we_lo;
            r_m_hi    <= w_e_hi;
            r_m_lo    <= w_e_lo;
        end
    end

    // W slot: advance M into W, dropping the entry if MEM raised an exception.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_w_valid <= 1'b0;
            r_w_we_hi <= 1'b0;
            r_w_we_lo <= 1'b0;
            r_w_hi    <= 32'h0;
            r_w_lo    <= 32'h0;
        end else if (!stallM) begin
            r_w_valid <= r_m_valid & ~flushM;
            r_w_we_hi <= r_m_we_hi;
            r_w_we_lo <= r_m_we_lo;
            r_w_hi    <= r_m_hi;
            r_w_lo    <= r_m_lo;
        end
    end

    // Architectural commit: each half updates only when the departing W entry writes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= RST_HI;
            r_lo <= RST_LO;
        end else if (!stallM) begin
            if (w_fwd_w_hi) begin
                r_hi <= r_w_hi;
            end
            if (w_fwd_w_lo) begin
                r_lo <= r_w_lo;
            end
        end
    end

    assign hi_arch = r_hi;
    assign lo_arch = r_lo;
    assign busy    = r_m_valid | r_w_valid;

endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - directed bench for hilo_unit
`timescale 1ns/1ps
module tb_hilo_unit;

    logic        clk;
    logic        rst;
    logic [2:0]  hilo_opE;
    logic [63:0] alu_outE;
    logic        stallE;
    logic        stallM;
    logic        flushM;
    logic [31:0] hiE;
    logic [31:0] loE;
    logic [31:0] hi_arch;
    logic [31:0] lo_arch;
    logic        busy;

    int total;
    int bad;

    hilo_unit #(.RST_HI(32'h0), .RST_LO(32'h0)) dut (
        .clk      (clk),
        .rst      (rst),
        .hilo_opE (hilo_opE),
        .alu_outE (alu_outE),
        .stallE   (stallE),
        .stallM   (stallM),
        .flushM   (flushM),
        .hiE      (hiE),
        .loE      (loE),
        .hi_arch  (hi_arch),
        .lo_arch  (lo_arch),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hilo_opE = 3'd0;
        alu_outE = 64'h0;
        stallE   = 1'b0;
        stallM   = 1'b0;
        flushM   = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst      = 1'b1;
        hilo_opE = 3'd1;
        alu_outE = 64'hDEAD_BEEF_CAFE_F00D;
        stallM   = 1'b1;
        flushM   = 1'b1;
        step();
        step();
        step();
        total++;
        if (hiE !== 32'h0 || loE !== 32'h0) begin
            bad++;
            $display("FAIL reset_fwd: hiE=%h loE=%h expected 0/0", hiE, loE);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy: busy=%b expected 0", busy);
        end
        total++;
        if (hi_arch !== 32'h0 || lo_arch !== 32'h0) begin
            bad++;
            $display("FAIL reset_arch: hi=%h lo=%h expected 0/0", hi_arch, lo_arch);
        end
        idle();
        rst = 1'b0;
        step();
        total++;
        if (busy !== 1'b0 || hi_arch !== 32'h0) begin
            bad++;
            $display("FAIL reset_release: busy=%b hi_arch=%h expected 0/0", busy, hi_arch);
        end
    endtask

    task automatic test_mult();
        hilo_opE = 3'd1;
        alu_outE = 64'h0000_0001_FFFF_FFFE;
        step();
        idle();
        total++;
        if (hiE !== 32'h1 || loE !== 32'hFFFF_FFFE) begin
            bad++;
            $display("FAIL mult_fwd: hiE=%h loE=%h expected 1/fffffffe", hiE, loE);
        end
        total++;
        if (busy !== 1'b1 || hi_arch !== 32'h0) begin
            bad++;
            $display("FAIL mult_pending: busy=%b hi_arch=%h expected 1/0", busy, hi_arch);
        end
        step();
        total++;
        if (hi_arch !== 32'h0 || hiE !== 32'h1) begin
            bad++;
            $display("FAIL mult_in_w: hi_arch=%h hiE=%h expected 0/1", hi_arch, hiE);
        end
        step();
        total++;
        if (hi_arch !== 32'h1 || lo_arch !== 32'hFFFF_FFFE) begin
            bad++;
            $display("FAIL mult_commit: hi=%h lo=%h expected 1/fffffffe", hi_arch, lo_arch);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL mult_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_mthi_mtlo();
        hilo_opE = 3'd2;
        alu_outE = 64'hFFFF_FFFF_0000_0005;
        step();
        hilo_opE = 3'd3;
        alu_outE = 64'hFFFF_FFFF_0000_0007;
        step();
        idle();
        total++;
        if (hiE !== 32'h5 || loE !== 32'h7) begin
            bad++;
            $display("FAIL mt_fwd: hiE=%h loE=%h expected 5/7", hiE, loE);
        end
        step();
        total++;
        if (hi_arch !== 32'h5 || lo_arch !== 32'hFFFF_FFFE) begin
            bad++;
            $display("FAIL mt_half_commit: hi=%h lo=%h expected 5/fffffffe", hi_arch, lo_arch);
        end
        step();
        total++;
        if (hi_arch !== 32'h5 || lo_arch !== 32'h7) begin
            bad++;
            $display("FAIL mt_commit: hi=%h lo=%h expected 5/7", hi_arch, lo_arch);
        end
    endtask

    task automatic test_madd_chain();
        hilo_opE = 3'd1;
        alu_outE = 64'h0000_0000_FFFF_FFFF;
        step();
        hilo_opE = 3'd4;
        alu_outE = 64'h1;
        step();
        hilo_opE = 3'd4;
        alu_outE = 64'h2;
        step();
        idle();
        total++;
        if (hiE !== 32'h1 || loE !== 32'h2) begin
            bad++;
            $display("FAIL madd_fwd: hiE=%h loE=%h expected 1/2", hiE, loE);
        end
        step();
        step();
        total++;
        if (hi_arch !== 32'h1 || lo_arch !== 32'h2) begin
            bad++;
            $display("FAIL madd_commit: hi=%h lo=%h expected 1/2", hi_arch, lo_arch);
        end
        hilo_opE = 3'd5;
        alu_outE = 64'h3;
        step();
        idle();
        total++;
        if (hiE !== 32'h0 || loE !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL msub_fwd: hiE=%h loE=%h expected 0/ffffffff", hiE, loE);
        end
        step();
        step();
    endtask

    task automatic test_flush();
        hilo_opE = 3'd1;
        alu_outE = 64'h0;
        step();
        idle();
        step();
        step();
        total++;
        if (hi_arch !== 32'h0 || lo_arch !== 32'h0) begin
            bad++;
            $display("FAIL flush_setup: hi=%h lo=%h expected 0/0", hi_arch, lo_arch);
        end
        hilo_opE = 3'd1;
        alu_outE = 64'hAAAA_AAAA_5555_5555;
        step();
        idle();
        total++;
        if (busy !== 1'b1 || hiE !== 32'hAAAA_AAAA) begin
            bad++;
            $display("FAIL flush_pending: busy=%b hiE=%h expected 1/aaaaaaaa", busy, hiE);
        end
        flushM = 1'b1;
        step();
        flushM = 1'b0;
        total++;
        if (busy !== 1'b0 || hiE !== 32'h0 || loE !== 32'h0) begin
            bad++;
            $display("FAIL flush_kill: busy=%b hiE=%h loE=%h expected 0/0/0", busy, hiE, loE);
        end
        step();
        step();
        total++;
        if (hi_arch !== 32'h0 || lo_arch !== 32'h0) begin
            bad++;
            $display("FAIL flush_arch: hi=%h lo=%h expected 0/0", hi_arch, lo_arch);
        end
        hilo_opE = 3'd1;
        alu_outE = 64'h1111_1111_2222_2222;
        step();
        hilo_opE = 3'd1;
        alu_outE = 64'h3333_3333_4444_4444;
        flushM   = 1'b1;
        step();
        idle();
        total++;
        if (hiE !== 32'h3333_3333 || loE !== 32'h4444_4444 || busy !== 1'b1) begin
            bad++;
            $display("FAIL flush_new_enters: hiE=%h loE=%h busy=%b expected 33333333/44444444/1", hiE, loE, busy);
        end
        step();
        step();
        total++;
        if (hi_arch !== 32'h3333_3333 || lo_arch !== 32'h4444_4444) begin
            bad++;
            $display("FAIL flush_survivor: hi=%h lo=%h expected 33333333/44444444", hi_arch, lo_arch);
        end
    endtask

    task automatic test_flush_under_stall();
        hilo_opE = 3'd1;
        alu_outE = 64'h0000_00A1_0000_00A2;
        step();
        hilo_opE = 3'd1;
        alu_outE = 64'h0000_00B1_0000_00B2;
        step();
        hilo_opE = 3'd1;
        alu_outE = 64'h0000_00C1_0000_00C2;
        stallM   = 1'b1;
        flushM   = 1'b1;
        step();
        idle();
        total++;
        if (hiE !== 32'hA1 || loE !== 32'hA2 || hi_arch !== 32'h3333_3333) begin
            bad++;
            $display("FAIL stallflush_hold: hiE=%h loE=%h hi_arch=%h expected a1/a2/33333333", hiE, loE, hi_arch);
        end
        step();
        total++;
        if (hi_arch !== 32'hA1 || lo_arch !== 32'hA2 || busy !== 1'b0) begin
            bad++;
            $display("FAIL stallflush_commit: hi=%h lo=%h busy=%b expected a1/a2/0", hi_arch, lo_arch, busy);
        end
        step();
        total++;
        if (hi_arch !== 32'hA1 || lo_arch !== 32'hA2) begin
            bad++;
            $display("FAIL stallflush_final: hi=%h lo=%h expected a1/a2", hi_arch, lo_arch);
        end
    endtask

    task automatic test_div_stall();
        int busy_seen;
        busy_seen = 0;
        hilo_opE = 3'd1;
        alu_outE = 64'h0000_0002_0000_0003;
        stallE   = 1'b1;
        for (int i = 0; i < 33; i++) begin
            step();
            if (busy !== 1'b0) busy_seen++;
        end
        total++;
        if (busy_seen !== 0) begin
            bad++;
            $display("FAIL div_stall_busy: busy cycles=%0d expected 0", busy_seen);
        end
        stallE = 1'b0;
        step();
        idle();
        total++;
        if (busy !== 1'b1 || hiE !== 32'h2 || loE !== 32'h3) begin
            bad++;
            $display("FAIL div_issue: busy=%b hiE=%h loE=%h expected 1/2/3", busy, hiE, loE);
        end
        stallM = 1'b1;
        hilo_opE = 3'd1;
        alu_outE = 64'h0000_0009_0000_0009;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (hi_arch !== 32'hA1 || hiE !== 32'h2 || busy !== 1'b1) begin
                bad++;
                $display("FAIL div_stallM_hold: cyc=%0d hi_arch=%h hiE=%h busy=%b expected a1/2/1", i, hi_arch, hiE, busy);
            end
        end
        idle();
        step();
        total++;
        if (hi_arch !== 32'hA1) begin
            bad++;
            $display("FAIL div_in_w: hi_arch=%h expected a1", hi_arch);
        end
        step();
        total++;
        if (hi_arch !== 32'h2 || lo_arch !== 32'h3 || busy !== 1'b0) begin
            bad++;
            $display("FAIL div_commit: hi=%h lo=%h busy=%b expected 2/3/0", hi_arch, lo_arch, busy);
        end
        step();
        total++;
        if (busy !== 1'b0 || hi_arch !== 32'h2) begin
            bad++;
            $display("FAIL div_single_write: busy=%b hi=%h expected 0/2", busy, hi_arch);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();
        rst = 1'b1;
        test_reset();
        test_mult();
        test_mthi_mtlo();
        test_madd_chain();
        test_flush();
        test_flush_under_stall();
        test_div_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
